// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned PC_WIDTH         = 32;
  localparam int unsigned INSTR_WIDTH      = 32;
  localparam int unsigned FETCH_FIFO_DEPTH = 2;
  localparam int unsigned PC_INCR          = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response and decode-side handshake bundle.
interface fetch_if;
  import fetch_pkg::*;

  logic                   imem_req_valid_o;
  logic [PC_WIDTH-1:0]    imem_req_addr_o;
  logic                   imem_req_ready_i;
  logic                   imem_rsp_valid_i;
  logic [INSTR_WIDTH-1:0] imem_rsp_data_i;
  logic                   instr_valid_o;
  logic [INSTR_WIDTH-1:0] instr_o;
  logic [PC_WIDTH-1:0]    instr_pc_o;
  logic                   instr_ready_i;

  modport master (
    output imem_req_valid_o, imem_req_addr_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
    output instr_valid_o, instr_o, instr_pc_o,
    input  instr_ready_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
    input  instr_valid_o, instr_o, instr_pc_o,
    output instr_ready_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of PC-tagged instructions with single-cycle flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = FETCH_FIFO_DEPTH,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  fetch_entry_t     data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Fetch sequencer: drives next-PC, issues one imem request at a time and
// buffers PC-tagged instructions for decode, killing responses on redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [PC_WIDTH-1:0] pc_i,
  output logic [PC_WIDTH-1:0] next_pc_o,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  fetch_if.master             bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;

  logic                req_valid;
  logic                req_fire;
  logic                rsp_keep;
  logic                instr_valid;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_empty;
  logic                fifo_full;
  logic [CNT_W-1:0]    fifo_count;
  fetch_entry_t        push_entry;
  fetch_entry_t        fifo_head;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .flush_i (redirect_i),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // A response always retires the outstanding request, even when it is killed.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          state_d = WAIT;
          pc_d    = pc_i;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_valid_i) state_d = IDLE;
        else if (redirect_i)      state_d = DROP;
      end
      DROP: begin
        if (bus.imem_rsp_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit check on issue guarantees the later push always has a free slot.
  always_comb begin
    req_valid   = rst_ni && (state_q == IDLE) &&
                  (fifo_count < CNT_W'(FIFO_DEPTH)) && !redirect_i;
    req_fire    = req_valid && bus.imem_req_ready_i;
    instr_valid = rst_ni && !fifo_empty && !redirect_i;
    fifo_pop    = instr_valid && bus.instr_ready_i;
    rsp_keep    = (state_q == WAIT) && bus.imem_rsp_valid_i && !redirect_i;
    fifo_push   = rsp_keep && (!fifo_full || fifo_pop);

    push_entry.instr = bus.imem_rsp_data_i;
    push_entry.pc    = pc_q;

    if (!rst_ni)         next_pc_o = pc_i;
    else if (redirect_i) next_pc_o = redirect_pc_i & ~PC_WIDTH'(3);
    else if (req_fire)   next_pc_o = pc_i + PC_WIDTH'(PC_INCR);
    else                 next_pc_o = pc_i;

    bus.imem_req_valid_o = req_valid;
    bus.imem_req_addr_o  = pc_i;
    bus.instr_valid_o    = instr_valid;
    bus.instr_o          = fifo_head.instr;
    bus.instr_pc_o       = fifo_head.pc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against a queue-based model.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        redir;
  logic [31:0] rpc;

  fetch_if bus ();

  fetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pc_i          (pc),
    .next_pc_o     (next_pc),
    .redirect_i    (redir),
    .redirect_pc_i (rpc),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  // Model: buffered instructions plus the one outstanding request.
  ent_t        m_q[$];
  bit          m_out;
  bit          m_kill;
  logic [31:0] m_out_pc;
  bit          e_fire;
  bit          e_iv;
  bit          e_req;
  logic [31:0] e_next;
  logic [31:0] pc_nxt;

  // Memory environment: one outstanding request, fixed or random latency.
  bit          mem_busy;
  int          mem_lat;
  int          lat_cfg;
  logic [31:0] mem_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 5) | 32'h13;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic compare();
    e_req  = rst_n && !m_out && (m_q.size() < DEPTH) && !redir;
    e_fire = e_req && bus.imem_req_ready_i;
    e_iv   = rst_n && (m_q.size() > 0) && !redir;
    if (!rst_n)     e_next = pc;
    else if (redir) e_next = {rpc[31:2], 2'b00};
    else if (e_fire) e_next = pc + 32'd4;
    else            e_next = pc;
    chk("req_valid", 32'(bus.imem_req_valid_o), 32'(e_req));
    if (e_req) chk("req_addr", bus.imem_req_addr_o, pc);
    chk("next_pc", next_pc, e_next);
    chk("instr_valid", 32'(bus.instr_valid_o), 32'(e_iv));
    if (e_iv) begin
      chk("instr", bus.instr_o, m_q[0].instr);
      chk("instr_pc", bus.instr_pc_o, m_q[0].pc);
    end
  endtask

  task automatic drive(input bit r, input logic [31:0] t, input bit rdy, input bit drdy);
    @(negedge clk);
    pc    = pc_nxt;
    redir = r;
    rpc   = t;
    bus.imem_req_ready_i = rdy;
    bus.instr_ready_i    = drdy;
    bus.imem_rsp_valid_i = mem_busy && (mem_lat == 0);
    bus.imem_rsp_data_i  = (mem_busy && (mem_lat == 0)) ? mem_word(mem_addr) : $urandom;
    #1;
    compare();
  endtask

  task automatic tick();
    bit          c_fire, c_rsp, c_redir, c_pop, c_dut_fire;
    logic [31:0] c_data, c_pc, c_addr;
    ent_t        e;
    c_fire     = e_fire;
    c_rsp      = bus.imem_rsp_valid_i;
    c_data     = bus.imem_rsp_data_i;
    c_redir    = redir;
    c_pop      = e_iv && bus.instr_ready_i;
    c_pc       = pc;
    c_dut_fire = bus.imem_req_valid_o && bus.imem_req_ready_i;
    c_addr     = bus.imem_req_addr_o;
    pc_nxt     = e_next;
    @(posedge clk);
    if (c_redir) begin
      m_q.delete();
      if (m_out && c_rsp) m_out = 0;
      else if (m_out)     m_kill = 1;
    end else begin
      if (c_pop) void'(m_q.pop_front());
      if (m_out && c_rsp) begin
        if (!m_kill) begin
          e.instr = c_data;
          e.pc    = m_out_pc;
          m_q.push_back(e);
        end
        m_out = 0;
      end
      if (c_fire) begin
        m_out    = 1;
        m_kill   = 0;
        m_out_pc = c_pc;
      end
    end
    if (c_rsp)         mem_busy = 0;
    else if (mem_busy) mem_lat--;
    if (c_dut_fire) begin
      mem_busy = 1;
      mem_addr = c_addr;
      mem_lat  = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
    end
  endtask

  task automatic step(input bit r, input logic [31:0] t, input bit rdy, input bit drdy);
    drive(r, t, rdy, drdy);
    tick();
  endtask

  task automatic quiet_inputs();
    redir = 0;
    rpc   = '0;
    bus.imem_req_ready_i = 0;
    bus.instr_ready_i    = 0;
    bus.imem_rsp_valid_i = 0;
    bus.imem_rsp_data_i  = '0;
  endtask

  task automatic clear_env();
    m_q.delete();
    m_out    = 0;
    m_kill   = 0;
    mem_busy = 0;
  endtask

  initial begin
    rst_n   = 0;
    pc      = 32'h1234;
    pc_nxt  = 32'h0;
    lat_cfg = 0;
    quiet_inputs();
    clear_env();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(bus.imem_req_valid_o), 32'h0);
    chk("rst_instr_valid", 32'(bus.instr_valid_o), 32'h0);
    chk("rst_next_pc", next_pc, 32'h1234);
    @(negedge clk);
    rst_n = 1;

    // Basic fetch from 0 with a one-cycle response
    drive(0, 0, 1, 0);
    chk("t1_req_valid", 32'(bus.imem_req_valid_o), 32'h1);
    chk("t1_addr", bus.imem_req_addr_o, 32'h0);
    chk("t1_next_pc", next_pc, 32'h4);
    tick();
    step(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("t1_instr_valid", 32'(bus.instr_valid_o), 32'h1);
    chk("t1_instr", bus.instr_o, 32'h13);
    chk("t1_instr_pc", bus.instr_pc_o, 32'h0);
    tick();
    step(0, 0, 0, 1);

    // Decode stalled: buffer fills at two entries, then requests stop
    pc_nxt = 32'h100;
    repeat (8) step(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    chk("t2_req_valid_full", 32'(bus.imem_req_valid_o), 32'h0);
    chk("t2_next_pc_hold", next_pc, 32'h108);
    chk("t2_head_pc", bus.instr_pc_o, 32'h100);
    chk("t2_head_instr", bus.instr_o, mem_word(32'h100));
    tick();
    step(0, 0, 1, 1);
    drive(0, 0, 0, 0);
    chk("t2_second_pc", bus.instr_pc_o, 32'h104);
    tick();
    repeat (2) step(0, 0, 0, 1);

    // Memory not ready for three cycles
    pc_nxt = 32'h300;
    repeat (3) begin
      drive(0, 0, 0, 0);
      chk("t3_valid_stable", 32'(bus.imem_req_valid_o), 32'h1);
      chk("t3_addr_stable", bus.imem_req_addr_o, 32'h300);
      chk("t3_next_pc_hold", next_pc, 32'h300);
      tick();
    end
    drive(0, 0, 1, 0);
    chk("t3_next_pc_fire", next_pc, 32'h304);
    tick();
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);

    // Redirect while waiting; late response must be dropped
    lat_cfg = 2;
    pc_nxt  = 32'h400;
    step(0, 0, 1, 0);
    drive(1, 32'h203, 0, 1);
    chk("t4_next_pc_redirect", next_pc, 32'h200);
    chk("t4_instr_valid", 32'(bus.instr_valid_o), 32'h0);
    tick();
    drive(0, 0, 0, 0);
    chk("t4_drop_no_req", 32'(bus.imem_req_valid_o), 32'h0);
    tick();
    drive(0, 0, 0, 0);
    chk("t4_late_rsp_no_req", 32'(bus.imem_req_valid_o), 32'h0);
    tick();
    drive(0, 0, 0, 0);
    chk("t4_req_after_drop", 32'(bus.imem_req_valid_o), 32'h1);
    chk("t4_req_addr", bus.imem_req_addr_o, 32'h200);
    chk("t4_fifo_empty", 32'(bus.instr_valid_o), 32'h0);
    tick();
    lat_cfg = 0;

    // Redirect coincident with a response and decode ready
    pc_nxt = 32'h500;
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    drive(1, 32'h600, 0, 1);
    chk("t5_rsp_seen", 32'(bus.imem_rsp_valid_i), 32'h1);
    chk("t5_no_pop", 32'(bus.instr_valid_o), 32'h0);
    chk("t5_next_pc", next_pc, 32'h600);
    tick();
    drive(0, 0, 0, 1);
    chk("t5_empty", 32'(bus.instr_valid_o), 32'h0);
    chk("t5_idle", 32'(bus.imem_req_valid_o), 32'h1);
    tick();

    // PC wrap, then asynchronous reset while waiting
    pc_nxt = 32'hFFFF_FFFC;
    drive(0, 0, 1, 0);
    chk("t6_wrap", next_pc, 32'h0);
    tick();
    #2;
    rst_n = 0;
    quiet_inputs();
    #1;
    chk("t6_rst_req_valid", 32'(bus.imem_req_valid_o), 32'h0);
    chk("t6_rst_instr_valid", 32'(bus.instr_valid_o), 32'h0);
    chk("t6_rst_next_pc", next_pc, pc);
    compare();
    clear_env();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    drive(0, 0, 0, 0);
    chk("t6_idle_after_rst", 32'(bus.imem_req_valid_o), 32'h1);
    tick();

    // Randomized traffic
    lat_cfg = -1;
    repeat (3000) begin
      step($urandom_range(0, 99) < 8, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
